// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage k resolves operand segment k; lower sum bits and upper operand bits travel
// forward with the carry. Flags are formed in the final stage.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int unsigned SEG    = WIDTH / STAGES;
  localparam int unsigned NG     = SEG / BLOCK;
  localparam int          SEG_I  = int'(SEG);
  localparam int          BLK_I  = int'(BLOCK);
  localparam int          NG_I   = int'(NG);
  localparam int          LAST_I = int'(STAGES) - 1;

  // One segment of lookahead addition: group G/P, then all group and bit carries
  // expanded as sum-of-products of the segment carry-in.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] s;
    logic [NG-1:0]  gg;
    logic [NG-1:0]  gp;
    logic [NG:0]    gc;
    logic           t;
    logic           pp;
    int             base;
    g = a & b;
    p = a ^ b;
    s = '0;
    for (int j = 0; j < NG_I; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLK_I; i++) begin
        gg[j] = g[j*BLK_I+i] | (p[j*BLK_I+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLK_I+i];
      end
    end
    gc[0] = cin;
    for (int j = 1; j <= NG_I; j++) begin
      t = 1'b0;
      for (int i = 0; i < j; i++) begin
        pp = gg[i];
        for (int m = i + 1; m < j; m++) pp = pp & gp[m];
        t = t | pp;
      end
      pp = cin;
      for (int m = 0; m < j; m++) pp = pp & gp[m];
      gc[j] = t | pp;
    end
    for (int j = 0; j < NG_I; j++) begin
      base = j * BLK_I;
      for (int i = 0; i < BLK_I; i++) begin
        t = 1'b0;
        for (int m = 0; m < i; m++) begin
          pp = g[base+m];
          for (int q = m + 1; q < i; q++) pp = pp & p[base+q];
          t = t | pp;
        end
        pp = gc[j];
        for (int q = 0; q < i; q++) pp = pp & p[base+q];
        s[base+i] = p[base+i] ^ (t | pp);
      end
    end
    return {gc[NG_I], s};
  endfunction

  // Per-stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1.
  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [WIDTH-1:0]  st_s [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] v;
  logic [STAGES:0]   rdy;

  assign st_a[0]     = A;
  assign st_b[0]     = B ^ {WIDTH{SUB}};
  assign st_s[0]     = '0;
  assign st_c[0]     = Cin ^ SUB;
  assign st_v[0]     = in_valid;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v[STAGES-1];

  // Stage valid bits; a stage advances whenever it is empty or downstream can take its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) v[k] <= st_v[k];
      end
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic [SEG:0]     res;
    logic [WIDTH-1:0] sum_nxt;

    assign res    = cla_seg(st_a[k][k*SEG_I +: SEG_I], st_b[k][k*SEG_I +: SEG_I], st_c[k]);
    assign rdy[k] = ~v[k] | rdy[k+1];

    // Splice this stage's segment into the forwarded partial sum.
    always_comb begin
      sum_nxt = st_s[k];
      sum_nxt[k*SEG_I +: SEG_I] = res[SEG-1:0];
    end

    if (k < LAST_I) begin : g_mid
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] s_r;
      logic             c_r;

      // Intermediate datapath register; loads only real entries, no reset needed.
      always_ff @(posedge clk) begin
        if (rdy[k] && st_v[k]) begin
          a_r <= st_a[k];
          b_r <= st_b[k];
          s_r <= sum_nxt;
          c_r <= res[SEG];
        end
      end

      assign st_a[k+1] = a_r;
      assign st_b[k+1] = b_r;
      assign st_s[k+1] = s_r;
      assign st_c[k+1] = c_r;
      assign st_v[k+1] = v[k];
    end else begin : g_last
      // Result and flag register; holds while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          S    <= '0;
          Cout <= 1'b0;
          V    <= 1'b0;
          Z    <= 1'b0;
        end else if (rdy[k] && st_v[k]) begin
          S    <= sum_nxt;
          Cout <= res[SEG];
          V    <= (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) && (sum_nxt[WIDTH-1] != st_a[k][WIDTH-1]);
          Z    <= ~|sum_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at WIDTH=32, BLOCK=4, STAGES=2.
module tb_pipelined_cla_addsub;

  localparam int unsigned W   = 32;
  localparam int          LAT = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         SUB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;
  logic         Z;

  int checks = 0;
  int errors = 0;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the random stream: {Cout,V,Z,S}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ov;
    be = b ^ {W{sub}};
    r  = {1'b0, a} + {1'b0, be} + (W+1)'(cin ^ sub);
    ov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {r[W], ov, ~|r[W-1:0], r[W-1:0]};
  endfunction

  // Drive one op into an empty pipe; return the packed result and cycles to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output logic [W+2:0] res, output int lat);
    @(negedge clk);
    A = a; B = b; Cin = cin; SUB = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {Cout, V, Z, S};
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Cout, V, Z} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got ov/c/v/z=%b want 0000", {out_valid, Cout, V, Z});
    end
    checks++;
    if (S !== '0) begin
      errors++;
      $display("FAIL reset_s got %h want 00000000", S);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_carry;
    logic [W+2:0] r;
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== {1'b1, 1'b0, 1'b1, 32'h0000_0000}) begin
      errors++;
      $display("FAIL add_wrap got c/v/z/s=%h want %h", r, {1'b1, 1'b0, 1'b1, 32'h0});
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL latency got %0d want %0d", lat, LAT);
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, r, lat);
    checks++;
    if (r !== {3'b000, 32'h2345_678A}) begin
      errors++;
      $display("FAIL add_cin got %h want %h", r, {3'b000, 32'h2345_678A});
    end
  endtask

  task automatic test_sub;
    logic [W+2:0] r;
    int lat;
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, r, lat);
    checks++;
    if (r !== {3'b000, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL sub_borrow got %h want %h", r, {3'b000, 32'hFFFF_FFFE});
    end
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, r, lat);
    checks++;
    if (r !== {3'b000, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL sub_borrow_in got %h want %h", r, {3'b000, 32'hFFFF_FFFD});
    end
  endtask

  task automatic test_overflow;
    logic [W+2:0] r;
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, lat);
    checks++;
    if (r !== {3'b010, 32'h8000_0000}) begin
      errors++;
      $display("FAIL add_ovf got %h want %h", r, {3'b010, 32'h8000_0000});
    end
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, r, lat);
    checks++;
    if (r !== {3'b110, 32'h7FFF_FFFF}) begin
      errors++;
      $display("FAIL sub_ovf got %h want %h", r, {3'b110, 32'h7FFF_FFFF});
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oa [4] = '{32'h1, 32'hA, 32'hFFFF_FFFF, 32'h0};
    logic [W-1:0] ob [4] = '{32'h2, 32'h3, 32'hFFFF_FFFF, 32'h0};
    logic         oc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         os [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W+2:0] ex [4] = '{{3'b000, 32'h3}, {3'b100, 32'h7},
                             {3'b100, 32'hFFFF_FFFF}, {3'b101, 32'h0}};
    int tx = 0;
    int rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (tx < 4);
      if (tx < 4) begin
        A = oa[tx]; B = ob[tx]; Cin = oc[tx]; SUB = os[tx];
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
          errors++;
          $display("FAIL stall_handshake cyc %0d got in_ready/out_valid=%b want 01", cyc, {in_ready, out_valid});
        end
        checks++;
        if ({Cout, V, Z, S} !== ex[0]) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got %h want %h", cyc, {Cout, V, Z, S}, ex[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({Cout, V, Z, S} !== ex[rx]) begin
          errors++;
          $display("FAIL b2b_result %0d got %h want %h", rx, {Cout, V, Z, S}, ex[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    checks++;
    if (rx != 4) begin
      errors++;
      $display("FAIL b2b_count got %0d want 4", rx);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_inflight;
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    A = 32'd5; B = 32'd6; Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    A = 32'd100; B = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, S} !== {1'b1, 32'd11}) begin
      errors++;
      $display("FAIL inflight_pre got valid/s=%h want %h", {out_valid, S}, {1'b1, 32'd11});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Cout, V, Z, S} !== '0) begin
      errors++;
      $display("FAIL inflight_reset got %h want 0", {out_valid, Cout, V, Z, S});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL inflight_emitted got %0d cycles valid want 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL inflight_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_random;
    logic [W+2:0] q[$];
    logic [W+2:0] exp_r;
    logic [W-1:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    int n = 400;
    int tx = 0;
    int rx = 0;
    logic pend = 1'b0;
    for (int cyc = 0; cyc < 20000 && rx < n; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        if (tx < n && $urandom_range(0, 3) != 0) begin
          A   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
          B   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
          Cin = 1'($urandom_range(0, 1));
          SUB = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (out_valid && out_ready) begin
        exp_r = (q.size() > 0) ? q.pop_front() : '0;
        checks++;
        if ({Cout, V, Z, S} !== exp_r) begin
          errors++;
          $display("FAIL random_result %0d got %h want %h", rx, {Cout, V, Z, S}, exp_r);
        end
        rx++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(A, B, Cin, SUB));
        tx++;
        pend = 1'b0;
      end
    end
    checks++;
    if (rx != n) begin
      errors++;
      $display("FAIL random_count got %0d want %0d", rx, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A   = '0;
    B   = '0;
    Cin = 1'b0;
    SUB = 1'b0;
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
